pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 135 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Two-entry ready/valid pipeline register with a skid slot. in_ready comes
//   straight from a flop, so there is no combinational path from out_ready back
//   upstream. The block still sustains one transfer per clock.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : asynchronous reset, active low
//   in_valid   : upstream offers in_data
//   in_ready   : block accepts in_data this cycle (registered)
//   in_data    : upstream payload, WIDTH bits
//   flush      : synchronous kill of all held entries; beats every other event
//   out_valid  : out_data holds a valid entry
//   out_ready  : downstream consumes out_data this cycle
//   out_data   : oldest held payload (main register contents, also when idle)
//   occupancy  : number of held entries, 0..2
//   stall_cnt  : saturating count of cycles with out_valid=1 and out_ready=0
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // The encoding doubles as the occupancy value.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic in_acc;
    logic out_acc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    assign in_acc  = in_valid & in_ready_q;
    assign out_acc = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (in_acc) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_acc && out_acc) begin
                    main_d = in_data;
                end else if (in_acc) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_acc) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready_q is low here, so only the drain side can move.
                if (out_acc) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush discards everything, including a payload offered this cycle.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        // in_ready is precomputed for the next cycle from the next state.
        in_ready_d = (state_d != FULL);

        // Stall accounting ignores flush.
        stall_d = stall_q;
        if (out_valid && !out_ready) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
//   Directed scenarios for pipe_skid_reg, followed by a randomized
//   valid/ready stream checked against a queue of expected payloads.
//   DUT is built with WIDTH=16, RESET_VAL=16'hA5A5 and CNT_W=3.
module tb_pipe_skid_reg;

    localparam int               WIDTH = 16;
    localparam logic [WIDTH-1:0] RVAL  = 16'hA5A5;
    localparam int               CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int checks;
    int errors;

    pipe_skid_reg #(
        .WIDTH(WIDTH),
        .RESET_VAL(RVAL),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset, then release it just after an edge; returns with in_ready high.
    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got out_valid=%b occ=%0d in_ready=%b, want 0/0/0",
                     out_valid, occupancy, in_ready);
        end
        checks++;
        if (out_data !== RVAL || stall_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: got out_data=%h stall=%0d, want %h/0",
                     out_data, stall_cnt, RVAL);
        end
        rst = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: got in_ready=%b, want 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] vec [3];
        vec[0] = 16'h0011;
        vec[1] = 16'h0022;
        vec[2] = 16'h0033;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_in_ready[%0d]: got %b, want 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== vec[i]) begin
                errors++;
                $display("FAIL stream_out[%0d]: got valid=%b data=%h, want 1/%h",
                         i, out_valid, out_data, vec[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0033 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_idle: got valid=%b data=%h occ=%0d, want 0/0033/0",
                     out_valid, out_data, occupancy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        tick();
        in_data = 16'h000B;
        tick();
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h000A) begin
            errors++;
            $display("FAIL bp_full: got occ=%0d in_ready=%b data=%h, want 2/0/000a",
                     occupancy, in_ready, out_data);
        end
        tick();
        checks++;
        if (out_data !== 16'h000A || occupancy !== 2'd2) begin
            errors++;
            $display("FAIL bp_hold: got data=%h occ=%0d, want 000a/2", out_data, occupancy);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h000B || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain1: got valid=%b data=%h in_ready=%b, want 1/000b/1",
                     out_valid, out_data, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL bp_drain2: got valid=%b occ=%0d, want 0/0", out_valid, occupancy);
        end
        // Stalled edges: entry of 0xB, and one extra hold cycle.
        checks++;
        if (stall_cnt !== 3'd2) begin
            errors++;
            $display("FAIL bp_stall_cnt: got %0d, want 2", stall_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0001;
        tick();
        // Flush in ONE with a payload offered: the payload must be discarded.
        flush   = 1'b1;
        in_data = 16'h000D;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data === 16'h000D) begin
            errors++;
            $display("FAIL flush_one: got valid=%b occ=%0d data=%h, want 0/0/not 000d",
                     out_valid, occupancy, out_data);
        end
        in_valid = 1'b1;
        in_data  = 16'h0001;
        tick();
        in_data = 16'h0002;
        tick();
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL flush_prefill: got occ=%0d, want 2", occupancy);
        end
        flush   = 1'b1;
        in_data = 16'h000C;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got valid=%b occ=%0d in_ready=%b, want 0/0/1",
                     out_valid, occupancy, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_data === 16'h000C) begin
                errors++;
                $display("FAIL flush_after[%0d]: got valid=%b data=%h, want 0/not 000c",
                         i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0055;
        tick();
        in_data = 16'h0066;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== RVAL || occupancy !== 2'd0 ||
            in_ready !== 1'b0 || stall_cnt !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h occ=%0d rdy=%b stall=%0d, want 0/%h/0/0/0",
                     out_valid, out_data, occupancy, in_ready, stall_cnt, RVAL);
        end
        #1;
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_release: got in_ready=%b valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0077;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_cnt !== 3'd5) begin
            errors++;
            $display("FAIL sat_mid: got %0d, want 5", stall_cnt);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_cnt !== 3'd7) begin
            errors++;
            $display("FAIL sat_final: got %0d, want 7", stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] q [$];
        logic [WIDTH-1:0] exp_v;
        logic [WIDTH-1:0] seq;
        int xfers;
        int cyc;
        do_reset();
        seq   = 16'h1000;
        xfers = 0;
        cyc   = 0;
        while (xfers < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = seq;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: got data=%h with empty model at cycle %0d",
                             out_data, cyc);
                end else begin
                    exp_v = q.pop_front();
                    if (out_data !== exp_v) begin
                        errors++;
                        $display("FAIL rand_data: got %h, want %h at cycle %0d",
                                 out_data, exp_v, cyc);
                    end
                end
                xfers++;
            end
            if (in_valid && in_ready) begin
                q.push_back(seq);
                seq = seq + 16'd1;
            end
            tick();
            cyc++;
            checks++;
            if (occupancy !== 2'(q.size())) begin
                errors++;
                $display("FAIL rand_occ: got %0d, want %0d at cycle %0d",
                         occupancy, q.size(), cyc);
            end
        end
        checks++;
        if (xfers < 10000) begin
            errors++;
            $display("FAIL rand_budget: got %0d transfers, want 10000", xfers);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
